// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/redirect control for a 5-stage in-order core
// Handles load-use bubbles, EX redirects and data-memory wait states with a sticky timeout flag.
module pipeline_hazard_ctrl #(
   parameter int PC_W        = 9,
   parameter int RF_ADDRESS  = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RF_ADDRESS-1:0] id_rs1,
   input  logic [RF_ADDRESS-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [RF_ADDRESS-1:0] ex_rd,
   input  logic                  ex_redirect,
   input  logic [PC_W-1:0]       ex_target,
   input  logic                  mem_access,
   input  logic                  dmem_ready,
   output logic                  pc_we,
   output logic                  if_id_we,
   output logic                  id_ex_we,
   output logic                  ex_mem_we,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  mem_wb_bubble,
   output logic                  pc_sel,
   output logic [PC_W-1:0]       pc_target,
   output logic [1:0]            state,
   output logic [15:0]           stall_cnt,
   output logic                  mem_timeout_err
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01
   } state_t;

   state_t            state_q, state_nxt;
   logic              pend_redirect, pend_redirect_nxt;
   logic [PC_W-1:0]   pend_target, pend_target_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              err_nxt;
   logic              load_use;
   logic              mem_stall;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));
   assign mem_stall = mem_access && !dmem_ready;
   assign state     = state_q;

   always_comb begin
      pc_we             = 1'b1;
      if_id_we          = 1'b1;
      id_ex_we          = 1'b1;
      ex_mem_we         = 1'b1;
      if_id_flush       = 1'b0;
      id_ex_flush       = 1'b0;
      mem_wb_bubble     = 1'b0;
      pc_sel            = 1'b0;
      pc_target         = ex_target;
      state_nxt         = state_q;
      pend_redirect_nxt = pend_redirect;
      pend_target_nxt   = pend_target;
      wait_nxt          = wait_cnt;
      err_nxt           = mem_timeout_err;

      case (state_q)
         RUN: begin
            if (mem_stall) begin
               pc_we             = 1'b0;
               if_id_we          = 1'b0;
               id_ex_we          = 1'b0;
               ex_mem_we         = 1'b0;
               mem_wb_bubble     = 1'b1;
               state_nxt         = MEM_WAIT;
               // EX is frozen for the whole wait, so its redirect is replayed on release
               pend_redirect_nxt = ex_redirect;
               pend_target_nxt   = ex_target;
               wait_nxt          = '0;
            end else if (ex_redirect) begin
               pc_sel      = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_we       = 1'b0;
               if_id_we    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!dmem_ready) begin
               pc_we         = 1'b0;
               if_id_we      = 1'b0;
               id_ex_we      = 1'b0;
               ex_mem_we     = 1'b0;
               mem_wb_bubble = 1'b1;
               if (wait_cnt != WAIT_MAX) begin
                  wait_nxt = wait_cnt + WAIT_W'(1);
               end
               if (wait_nxt == WAIT_MAX) begin
                  err_nxt = 1'b1;
               end
            end else begin
               state_nxt         = RUN;
               wait_nxt          = '0;
               pend_redirect_nxt = 1'b0;
               if (pend_redirect) begin
                  pc_sel      = 1'b1;
                  pc_target   = pend_target;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  pc_we       = 1'b0;
                  if_id_we    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= RUN;
         pend_redirect   <= 1'b0;
         pend_target     <= '0;
         wait_cnt        <= '0;
         stall_cnt       <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         state_q         <= state_nxt;
         pend_redirect   <= pend_redirect_nxt;
         pend_target     <= pend_target_nxt;
         wait_cnt        <= wait_nxt;
         mem_timeout_err <= err_nxt;
         if (!pc_we && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
   logic [8:0]  ex_target;
   logic        mem_access, dmem_ready;
   logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
   logic        if_id_flush, id_ex_flush, mem_wb_bubble, pc_sel;
   logic [8:0]  pc_target;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic        mem_timeout_err;
   logic [7:0]  ctrl;

   int total = 0;
   int bad   = 0;

   // control bundle order: pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_bubble, pc_sel
   localparam logic [7:0] C_RUN   = 8'hF0;
   localparam logic [7:0] C_LOAD  = 8'h34;
   localparam logic [7:0] C_REDIR = 8'hFD;
   localparam logic [7:0] C_STALL = 8'h02;

   assign ctrl = {pc_we, if_id_we, id_ex_we, ex_mem_we,
                  if_id_flush, id_ex_flush, mem_wb_bubble, pc_sel};

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_redirect     (ex_redirect),
      .ex_target       (ex_target),
      .mem_access      (mem_access),
      .dmem_ready      (dmem_ready),
      .pc_we           (pc_we),
      .if_id_we        (if_id_we),
      .id_ex_we        (id_ex_we),
      .ex_mem_we       (ex_mem_we),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_bubble   (mem_wb_bubble),
      .pc_sel          (pc_sel),
      .pc_target       (pc_target),
      .state           (state),
      .stall_cnt       (stall_cnt),
      .mem_timeout_err (mem_timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       u1, u2, mr;
      logic [4:0] rd;
      logic       redir;
      logic [8:0] tgt;
      logic       macc, rdy;
      logic [7:0] exp_ctrl;
      logic [8:0] exp_tgt;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic redir,
                               input logic [8:0] tgt, input logic macc,
                               input logic rdy, input logic [7:0] ec,
                               input logic [8:0] et);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
      v.redir = redir; v.tgt = tgt; v.macc = macc; v.rdy = rdy;
      v.exp_ctrl = ec; v.exp_tgt = et;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_mem_read = 0; ex_rd = 0; ex_redirect = 0; ex_target = 9'h000;
      mem_access = 0; dmem_ready = 0;
   endtask

   task automatic set_load_use();
      id_rs1 = 5'd3; id_uses_rs1 = 1; ex_mem_read = 1; ex_rd = 5'd3;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      int exp_stall;
      reset = 1'b1;
      idle();

      vecs[0] = mk(0, 0, 0, 0, 0, 0, 0, 9'h123, 0, 0, C_RUN,   9'h123);
      vecs[1] = mk(0, 5, 0, 1, 1, 5, 0, 9'h011, 0, 0, C_LOAD,  9'h011);
      vecs[2] = mk(0, 0, 1, 0, 1, 0, 0, 9'h022, 0, 0, C_RUN,   9'h022);
      vecs[3] = mk(7, 2, 1, 1, 1, 7, 0, 9'h033, 0, 0, C_LOAD,  9'h033);
      vecs[4] = mk(7, 7, 0, 0, 1, 7, 0, 9'h044, 0, 0, C_RUN,   9'h044);
      vecs[5] = mk(7, 7, 1, 1, 0, 7, 0, 9'h055, 0, 0, C_RUN,   9'h055);
      vecs[6] = mk(0, 0, 0, 0, 0, 0, 1, 9'h040, 0, 0, C_REDIR, 9'h040);
      vecs[7] = mk(4, 0, 1, 0, 1, 4, 1, 9'h1A0, 0, 0, C_REDIR, 9'h1A0);
      vecs[8] = mk(0, 9, 0, 1, 1, 9, 0, 9'h066, 1, 1, C_LOAD,  9'h066);

      // reset values and RUN defaults while reset is held
      reset = 1'b0;
      ex_target = 9'h0AA;
      #2;
      check("rst_state", 32'(state), 0);
      check("rst_stall", 32'(stall_cnt), 0);
      check("rst_err", 32'(mem_timeout_err), 0);
      check("rst_ctrl", 32'(ctrl), 32'(C_RUN));
      check("rst_tgt", 32'(pc_target), 32'h0AA);

      // single-cycle load-use bubble
      do_reset();
      id_rs2 = 5'd5; id_uses_rs2 = 1; ex_mem_read = 1; ex_rd = 5'd5;
      #1;
      check("lu_ctrl", 32'(ctrl), 32'(C_LOAD));
      tick();
      idle();
      #1;
      check("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
      check("lu_stall_cnt", 32'(stall_cnt), 1);

      // table of single-cycle RUN vectors
      do_reset();
      exp_stall = 0;
      for (int i = 0; i < 9; i++) begin
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
         ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd;
         ex_redirect = vecs[i].redir; ex_target = vecs[i].tgt;
         mem_access = vecs[i].macc; dmem_ready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
         check($sformatf("vec%0d_tgt", i), 32'(pc_target), 32'(vecs[i].exp_tgt));
         check($sformatf("vec%0d_state", i), 32'(state), 0);
         if (vecs[i].exp_ctrl[7] == 1'b0) exp_stall++;
         tick();
      end
      idle();
      check("vec_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

      // memory wait of three stall cycles, plain release
      do_reset();
      mem_access = 1; dmem_ready = 0; ex_target = 9'h155;
      #1;
      check("mw_c1_ctrl", 32'(ctrl), 32'(C_STALL));
      check("mw_c1_state", 32'(state), 0);
      for (int i = 2; i <= 3; i++) begin
         tick();
         check($sformatf("mw_c%0d_ctrl", i), 32'(ctrl), 32'(C_STALL));
         check($sformatf("mw_c%0d_state", i), 32'(state), 1);
      end
      tick();
      dmem_ready = 1;
      #1;
      check("mw_rel_ctrl", 32'(ctrl), 32'(C_RUN));
      check("mw_rel_tgt", 32'(pc_target), 32'h155);
      tick();
      idle();
      #1;
      check("mw_after_state", 32'(state), 0);
      check("mw_stall_cnt", 32'(stall_cnt), 3);

      // redirect captured at stall entry and replayed on release, beating load-use
      do_reset();
      mem_access = 1; dmem_ready = 0; ex_redirect = 1; ex_target = 9'h080;
      #1;
      check("rd_c1_ctrl", 32'(ctrl), 32'(C_STALL));
      check("rd_c1_tgt", 32'(pc_target), 32'h080);
      tick();
      ex_redirect = 0; ex_target = 9'h1FF;
      #1;
      check("rd_c2_ctrl", 32'(ctrl), 32'(C_STALL));
      check("rd_c2_tgt", 32'(pc_target), 32'h1FF);
      tick();
      dmem_ready = 1;
      set_load_use();
      #1;
      check("rd_rel_ctrl", 32'(ctrl), 32'(C_REDIR));
      check("rd_rel_tgt", 32'(pc_target), 32'h080);
      tick();
      idle();
      ex_target = 9'h0F0;
      #1;
      check("rd_after_ctrl", 32'(ctrl), 32'(C_RUN));
      check("rd_after_tgt", 32'(pc_target), 32'h0F0);
      check("rd_after_state", 32'(state), 0);

      // load-use honoured on a release without a pending redirect
      do_reset();
      mem_access = 1; dmem_ready = 0;
      tick();
      dmem_ready = 1;
      set_load_use();
      #1;
      check("rlu_ctrl", 32'(ctrl), 32'(C_LOAD));
      tick();
      idle();
      #1;
      check("rlu_stall_cnt", 32'(stall_cnt), 2);

      // timeout after sixteen not-ready cycles, then asynchronous reset mid-wait
      do_reset();
      mem_access = 1; dmem_ready = 0;
      for (int i = 0; i < 15; i++) tick();
      check("to_err_pre", 32'(mem_timeout_err), 0);
      tick();
      check("to_err_set", 32'(mem_timeout_err), 1);
      check("to_state", 32'(state), 1);
      tick();
      tick();
      check("to_err_sticky", 32'(mem_timeout_err), 1);
      check("to_ctrl", 32'(ctrl), 32'(C_STALL));
      check("to_stall_cnt", 32'(stall_cnt), 18);
      #2;
      reset = 1'b0;
      #1;
      check("to_rst_state", 32'(state), 0);
      check("to_rst_err", 32'(mem_timeout_err), 0);
      check("to_rst_stall", 32'(stall_cnt), 0);
      idle();
      #1;
      check("to_rst_ctrl", 32'(ctrl), 32'(C_RUN));
      reset = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter PC_W, default 9, width of program counter and redirect target.
REQ-002 Parameter RF_ADDRESS, default 5, width of register-file address fields.
REQ-003 Parameter MEM_TIMEOUT, default 15, MEM_WAIT cycles before timeout error is flagged.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 id_rs1, id_rs2  input  RF_ADDRESS each  source registers of the instruction in IF/ID.
REQ-007 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-008 ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-009 ex_rd  input  RF_ADDRESS  destination register of the ID/EX instruction.
REQ-010 ex_redirect  input  1  branch taken, JAL or JALR resolved in EX.
REQ-011 ex_target  input  PC_W  redirect target PC from EX.
REQ-012 mem_access  input  1  EX/MEM instruction performs a data-memory read or write.
REQ-013 dmem_ready  input  1  data memory completes the current access this cycle.
REQ-014 pc_we, if_id_we, id_ex_we, ex_mem_we  output  1 each  stage register write enables.
REQ-015 if_id_flush, id_ex_flush  output  1 each  load a bubble (all zeros) into that stage register.
REQ-016 mem_wb_bubble  output  1  load a bubble into MEM/WB.
REQ-017 pc_sel  output  1  select pc_target over PC+4 for the next PC.
REQ-018 pc_target  output  PC_W  redirect target.
REQ-019 state  output  2  FSM state: RUN=00, MEM_WAIT=01.
REQ-020 stall_cnt  output  16  saturating count of cycles with pc_we=0.
REQ-021 mem_timeout_err  output  1  sticky timeout flag.

Function
REQ-022 All outputs SHALL be combinational from the current state, the registered fields and the inputs; no added latency.
REQ-023 Load-use hazard SHALL be defined as ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-024 Default in RUN: all write enables 1, all flushes and bubble 0, pc_sel 0.
REQ-025 Priority in RUN: memory stall > redirect > load-use.
REQ-026 In RUN with mem_access=1 and dmem_ready=0: all write enables 0 and mem_wb_bubble=1; next state MEM_WAIT; pend_redirect<=ex_redirect and pend_target<=ex_target.
REQ-027 In RUN with ex_redirect=1 and no memory stall: pc_sel=1, pc_target=ex_target, if_id_flush=1, id_ex_flush=1, pc_we=1; state stays RUN.
REQ-028 In RUN with a load-use hazard and no higher-priority event: pc_we=0, if_id_we=0, id_ex_flush=1, other enables 1; exactly one bubble is inserted.
REQ-029 In MEM_WAIT with dmem_ready=0: all enables 0 and mem_wb_bubble=1; wait_cnt increments, saturating at MEM_TIMEOUT.
REQ-030 When wait_cnt reaches MEM_TIMEOUT, mem_timeout_err SHALL be set; it stays set until reset, and waiting continues.
REQ-031 In MEM_WAIT with dmem_ready=1: all enables 1 and mem_wb_bubble=0; next state RUN; wait_cnt cleared.
REQ-032 In that release cycle, if pend_redirect=1, the block SHALL apply pc_sel=1, pc_target=pend_target, if_id_flush=1 and id_ex_flush=1, then clear pend_redirect.
REQ-033 In that release cycle, a load-use hazard SHALL apply REQ-028 only when pend_redirect=0.
REQ-034 stall_cnt increments on every cycle with pc_we=0 and holds at 16'hFFFF.
REQ-035 pc_target SHALL equal ex_target whenever pc_sel=0.

Reset
REQ-036 Asserting reset low at any time, including mid-MEM_WAIT, SHALL immediately force state=RUN and clear pend_redirect, pend_target, wait_cnt, stall_cnt and mem_timeout_err.
REQ-037 After reset, outputs SHALL take the RUN defaults of REQ-024 immediately, driven by the inputs.

Verification
REQ-038 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_we=0, if_id_we=0, id_ex_flush=1 for one cycle; stall_cnt=1.
REQ-039 ex_rd=0 with matching rs1 and ex_mem_read=1 -> no stall; all enables 1.
REQ-040 Redirect: ex_redirect=1, ex_target=9'h040 -> pc_sel=1, pc_target=9'h040, both flushes 1, state stays 00.
REQ-041 Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, state=01; release cycle enables 1, state returns 00; stall_cnt=3.
REQ-042 Redirect during stall: ex_redirect=1, ex_target=9'h080 at stall entry, dmem_ready after 2 cycles -> release cycle pc_sel=1, pc_target=9'h080, flushes 1.
REQ-043 Timeout and reset: dmem_ready held 0 for 16 cycles -> mem_timeout_err=1; reset low mid-wait -> state=00, err=0, stall_cnt=0.
